// File: rtl/lb_pkg.sv
// Shared defaults and the tap-to-RAM rotation for the line buffer bank.
// Pure constants/functions; no latency, no flow control.
package lb_pkg;

  localparam int LB_DATA_WIDTH = 8;
  localparam int LB_LINE_WIDTH = 2048;
  localparam int LB_NUM_LINES  = 3;

  // RAM holding tap k when wr_sel receives the current line:
  // (wr_sel + num_lines-1-k) mod (num_lines-1), the sum never exceeds two ring lengths.
  function automatic int lb_tap_ram(input int wr_sel, input int k, input int num_lines);
    int sum;
    sum = wr_sel + (num_lines - 1 - k);
    if (sum >= num_lines - 1) begin
      sum = sum - (num_lines - 1);
    end
    return sum;
  endfunction

endpackage

// File: rtl/lb_line_ram.sv
// One line of pixel storage: read-first, registered read, 1-cycle latency.
// No backpressure; i_en gates both the access and the read register.
module lb_line_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2048,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array contents are deliberately left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/line_buffer_bank.sv
// Vertical tap line buffer: NUM_LINES-1 ring RAMs feed one column of taps per pixel.
// Latency 1 cycle from in_valid; no backpressure, the source is never stalled.
module line_buffer_bank
  import lb_pkg::*;
#(
  parameter int DATA_WIDTH = LB_DATA_WIDTH,
  parameter int LINE_WIDTH = LB_LINE_WIDTH,
  parameter int NUM_LINES  = LB_NUM_LINES,
  parameter int COL_W      = $clog2(LINE_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_sof,
  input  logic                            in_eol,
  output logic                            out_valid,
  output logic [NUM_LINES*DATA_WIDTH-1:0] out_taps,
  output logic [COL_W-1:0]                out_col,
  output logic                            out_eol,
  output logic                            out_window_ready,
  output logic                            err_overrun
);

  localparam int NUM_RAMS = NUM_LINES - 1;
  localparam int SEL_W    = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;
  localparam int LF_W     = $clog2(NUM_LINES);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_RAMS - 1);
  localparam logic [LF_W-1:0]  LF_FULL  = LF_W'(NUM_RAMS);

  logic [COL_W-1:0] r_col;
  logic [SEL_W-1:0] r_wr_sel;
  logic [LF_W-1:0]  r_lines_filled;
  logic             r_err_overrun;

  logic [COL_W-1:0] w_col;
  logic [SEL_W-1:0] w_sel;
  logic [LF_W-1:0]  w_lf;
  logic             w_overrun;
  logic             w_eol;
  logic [COL_W-1:0] w_col_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [LF_W-1:0]  w_lf_nxt;

  // sof overrides the running state for its own pixel, then eol advances from there.
  always_comb begin
    w_col     = in_sof ? '0 : r_col;
    w_sel     = in_sof ? '0 : r_wr_sel;
    w_lf      = in_sof ? '0 : r_lines_filled;
    w_overrun = !in_eol && (w_col == COL_LAST);
    w_eol     = in_eol || w_overrun;
    w_col_nxt = w_eol ? '0 : w_col + 1'b1;
    w_sel_nxt = w_sel;
    w_lf_nxt  = w_lf;
    if (w_eol) begin
      w_sel_nxt = (w_sel == SEL_LAST) ? '0 : w_sel + 1'b1;
      if (w_lf != LF_FULL) begin
        w_lf_nxt = w_lf + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col          <= '0;
      r_wr_sel       <= '0;
      r_lines_filled <= '0;
      r_err_overrun  <= 1'b0;
    end else if (in_valid) begin
      r_col          <= w_col_nxt;
      r_wr_sel       <= w_sel_nxt;
      r_lines_filled <= w_lf_nxt;
      r_err_overrun  <= (r_err_overrun & ~in_sof) | w_overrun;
    end
  end

  logic [DATA_WIDTH-1:0] w_ram_rdata [NUM_RAMS];

  for (genvar g = 0; g < NUM_RAMS; g++) begin : g_ram
    lb_line_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (LINE_WIDTH),
      .ADDR_W    (COL_W)
    ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .i_en   (in_valid),
      .i_we   (w_sel == SEL_W'(g)),
      .i_addr (w_col),
      .i_wdata(in_data),
      .o_rdata(w_ram_rdata[g])
    );
  end

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_tap0;
  logic [COL_W-1:0]      r_out_col;
  logic                  r_out_eol;
  logic                  r_out_ready;
  logic [SEL_W-1:0]      r_tap_ram [NUM_RAMS];

  // The RAM-to-tap mapping is captured alongside the read so it matches the returned data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_tap0      <= '0;
      r_out_col   <= '0;
      r_out_eol   <= 1'b0;
      r_out_ready <= 1'b0;
      for (int k = 0; k < NUM_RAMS; k++) begin
        r_tap_ram[k] <= '0;
      end
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_tap0      <= in_data;
        r_out_col   <= w_col;
        r_out_eol   <= w_eol;
        r_out_ready <= (w_lf >= LF_FULL);
        for (int k = 1; k < NUM_LINES; k++) begin
          r_tap_ram[k-1] <= SEL_W'(lb_tap_ram(32'(w_sel), k, NUM_LINES));
        end
      end
    end
  end

  logic [NUM_LINES*DATA_WIDTH-1:0] w_taps;

  always_comb begin
    w_taps                 = '0;
    w_taps[DATA_WIDTH-1:0] = r_tap0;
    for (int k = 1; k < NUM_LINES; k++) begin
      w_taps[k*DATA_WIDTH +: DATA_WIDTH] = w_ram_rdata[r_tap_ram[k-1]];
    end
  end

  assign out_valid        = r_out_valid;
  assign out_taps         = w_taps;
  assign out_col          = r_out_col;
  assign out_eol          = r_out_eol;
  assign out_window_ready = r_out_ready;
  assign err_overrun      = r_err_overrun;

endmodule

// File: tb/tb_line_buffer_bank.sv
// Bench for line_buffer_bank: a line-history model predicts each output column,
// expectations are queued on drive and popped when out_valid appears.
module tb_line_buffer_bank;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int NL = 3;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [DW-1:0]  in_data;
  logic           in_sof;
  logic           in_eol;
  logic           out_valid;
  logic [NL*DW-1:0] out_taps;
  logic [CW-1:0]  out_col;
  logic           out_eol;
  logic           out_window_ready;
  logic           err_overrun;

  always #5 clk = ~clk;

  line_buffer_bank #(
    .DATA_WIDTH(DW),
    .LINE_WIDTH(LW),
    .NUM_LINES (NL),
    .COL_W     (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_sof          (in_sof),
    .in_eol          (in_eol),
    .out_valid       (out_valid),
    .out_taps        (out_taps),
    .out_col         (out_col),
    .out_eol         (out_eol),
    .out_window_ready(out_window_ready),
    .err_overrun     (err_overrun)
  );

  typedef struct {
    logic [CW-1:0]    col;
    logic             eol;
    logic             ready;
    logic [NL*DW-1:0] taps;
    logic [NL*DW-1:0] mask;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [DW-1:0] hist     [0:63][0:LW-1];
  bit            hist_vld [0:63][0:LW-1];
  int            m_col;
  int            m_line;
  bit            m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_col  = 0;
    m_line = 0;
    m_err  = 1'b0;
    foreach (hist_vld[i, j]) hist_vld[i][j] = 1'b0;
  endtask

  // Tap k is the pixel k lines above in the same column, known only when that line reached it.
  task automatic model_pixel(input logic [DW-1:0] d, input bit s, input bit e, output exp_t x);
    bit ovr;
    if (s) model_clear();
    ovr     = !e && (m_col == LW - 1);
    x.col   = CW'(m_col);
    x.eol   = e || ovr;
    x.ready = (m_line >= NL - 1);
    x.taps  = '0;
    x.mask  = '0;
    x.taps[DW-1:0] = d;
    x.mask[DW-1:0] = '1;
    if (x.ready) begin
      for (int k = 1; k < NL; k++) begin
        if (hist_vld[m_line-k][m_col]) begin
          x.taps[k*DW +: DW] = hist[m_line-k][m_col];
          x.mask[k*DW +: DW] = '1;
        end
      end
    end
    hist[m_line][m_col]     = d;
    hist_vld[m_line][m_col] = 1'b1;
    if (x.eol) begin
      m_col  = 0;
      m_line = m_line + 1;
    end else begin
      m_col = m_col + 1;
    end
    if (ovr) m_err = 1'b1;
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit s, input bit e);
    exp_t x;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    in_sof   = s;
    in_eol   = e;
    if (v) begin
      model_pixel(d, s, e, x);
      sb_q.push_back(x);
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, v);
    if (out_valid) begin
      check("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        check("out_col", out_col, x.col);
        check("out_eol", out_eol, x.eol);
        check("out_window_ready", out_window_ready, x.ready);
        check("out_taps", out_taps & x.mask, x.taps);
      end
    end
    check("err_overrun", err_overrun, m_err);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic send_line(input int tag, input int n, input bit sof_first, input bit eol_last);
    for (int c = 0; c < n; c++) begin
      cycle(1'b1, 8'(16 * tag + c), sof_first && (c == 0), eol_last && (c == n - 1));
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
    model_clear();
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_taps", out_taps, 0);
    check("rst_out_col", out_col, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_ready", out_window_ready, 0);
    check("rst_err", err_overrun, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Three 4-pixel lines opening a frame.
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 4; c++) begin
        cycle(1'b1, 8'(16 * l + c), (l == 0) && (c == 0), c == 3);
        check("req21_ready", out_window_ready, l == 2);
        if (l == 2 && c == 1) check("req21_taps", out_taps, 24'h011121);
      end
    end

    // Input gap mid-line.
    send_line(3, 2, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 1'b0, 1'b0);
    check("req22_col_after_gap", out_col, 2);
    cycle(1'b1, 8'h33, 1'b0, 1'b1);

    // Line overrun: eight pixels without eol.
    send_line(4, 8, 1'b0, 1'b0);
    check("req23_eol", out_eol, 1);
    check("req23_err", err_overrun, 1);
    cycle(1'b1, 8'h50, 1'b0, 1'b0);
    check("req23_col_wrap", out_col, 0);
    cycle(1'b1, 8'h51, 1'b0, 1'b0);
    cycle(1'b1, 8'h52, 1'b0, 1'b0);
    cycle(1'b1, 8'h53, 1'b0, 1'b1);
    check("req23_err_sticky", err_overrun, 1);

    // sof arriving mid-line restarts the window.
    send_line(6, 2, 1'b0, 1'b0);
    cycle(1'b1, 8'h70, 1'b1, 1'b0);
    check("req24_sof_ready", out_window_ready, 0);
    check("req24_sof_col", out_col, 0);
    check("req24_err_clr", err_overrun, 0);
    cycle(1'b1, 8'h71, 1'b0, 1'b0);
    cycle(1'b1, 8'h72, 1'b0, 1'b0);
    cycle(1'b1, 8'h73, 1'b0, 1'b1);
    send_line(8, 4, 1'b0, 1'b1);
    check("req24_line1_ready", out_window_ready, 0);
    send_line(9, 4, 1'b0, 1'b1);
    check("req24_line2_ready", out_window_ready, 1);

    // Single-pixel line, then a 4-pixel line.
    cycle(1'b1, 8'hA0, 1'b1, 1'b1);
    check("req26_single_eol", out_eol, 1);
    send_line(11, 4, 1'b0, 1'b1);
    check("req26_last_col", out_col, 3);
    check("req26_not_ready", out_window_ready, 0);
    cycle(1'b1, 8'hC0, 1'b0, 1'b0);
    check("req26_filled", out_window_ready, 1);
    check("req26_taps", out_taps, 24'hA0B0C0);

    // Reset mid-line at col 3.
    cycle(1'b1, 8'hC1, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hC3;
    rst      = 1'b1;
    #1;
    check("req25_valid", out_valid, 0);
    check("req25_taps", out_taps, 0);
    check("req25_col", out_col, 0);
    check("req25_ready", out_window_ready, 0);
    check("req25_err", err_overrun, 0);
    @(posedge clk);
    #1;
    check("req25_valid_hold", out_valid, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    model_clear();
    cycle(1'b1, 8'hD0, 1'b0, 1'b0);
    check("req25_first_col", out_col, 0);
    check("req25_first_ready", out_window_ready, 0);
    cycle(1'b1, 8'hD1, 1'b0, 1'b1);

    // Random-data frame.
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 5; c++) begin
        cycle(1'b1, 8'($urandom), (l == 0) && (c == 0), c == 4);
      end
    end

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
